// File: rtl/audio_voice_mixer.sv
// audio_voice_mixer: four-voice gain/sum/limit/fade output stage feeding the audio codec
// controller. One sample is captured in IDLE when the controller has room. It is scaled,
// summed, clipped and faded over four registered stages, then written with a one-cycle
// handshake.
//
// Ports:
//   CLOCK_50           system clock
//   resetn             asynchronous active-low reset
//   melody_in .. hihat_in  signed 32-bit voice samples (captured in IDLE)
//   gains              per-voice 4-bit gain: [3:0] melody, [7:4] kick, [11:8] snare,
//                      [15:12] hihat
//   game_over          level: fade out while 1, fade in while 0
//   audio_out_allowed  controller FIFO has room
//   clip_clear         one-cycle clear of the sticky clip flag
//   left_out/right_out signed mixed sample (identical)
//   write_audio_out    write strobe, high only in WAIT_WR while allowed
//   clip               sticky saturation flag
//   fade_level         current fade multiplier, 256 = unity
module audio_voice_mixer #(
  parameter int          LIMIT     = 120000000,
  parameter int unsigned FADE_STEP = 48
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic signed [31:0] melody_in,
  input  logic signed [31:0] kick_in,
  input  logic signed [31:0] snare_in,
  input  logic signed [31:0] hihat_in,
  input  logic        [15:0] gains,
  input  logic               game_over,
  input  logic               audio_out_allowed,
  input  logic               clip_clear,
  output logic signed [31:0] left_out,
  output logic signed [31:0] right_out,
  output logic               write_audio_out,
  output logic               clip,
  output logic        [8:0]  fade_level
);

  localparam int unsigned CntW = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam logic signed [34:0] LimPos = 35'(LIMIT);
  localparam logic signed [34:0] LimNeg = -LimPos;

  typedef enum logic [2:0] {StIdle, StScale, StSumSat, StFade, StWaitWr} state_e;

  state_e             state_q;
  logic signed [31:0] in_q   [4];
  logic        [3:0]  gain_q [4];
  logic signed [32:0] p_q    [4];
  logic signed [34:0] sat_q;
  logic [CntW-1:0]    cnt_q;

  logic signed [36:0] prod   [4];
  logic signed [32:0] p_d    [4];
  logic signed [34:0] sum_s;
  logic signed [34:0] sat_d;
  logic               clip_d;
  logic signed [44:0] fade_prod;
  logic signed [31:0] fade_out;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      // Gain is zero-extended so 15 stays positive in the signed multiply.
      prod[i] = 37'(in_q[i]) * 37'($signed({1'b0, gain_q[i]}));
      p_d[i]  = 33'(prod[i] >>> 4);
    end
    sum_s  = 35'(p_q[0]) + 35'(p_q[1]) + 35'(p_q[2]) + 35'(p_q[3]);
    sat_d  = sum_s;
    clip_d = 1'b0;
    if (sum_s > LimPos) begin
      sat_d  = LimPos;
      clip_d = 1'b1;
    end else if (sum_s < LimNeg) begin
      sat_d  = LimNeg;
      clip_d = 1'b1;
    end
    fade_prod = 45'(sat_q) * 45'($signed({1'b0, fade_level}));
    fade_out  = 32'(fade_prod >>> 8);
  end

  // Combinational so the strobe tracks backpressure within the same cycle.
  assign write_audio_out = (state_q == StWaitWr) && audio_out_allowed;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      for (int i = 0; i < 4; i++) begin
        in_q[i]   <= '0;
        gain_q[i] <= '0;
        p_q[i]    <= '0;
      end
      sat_q      <= '0;
      left_out   <= '0;
      right_out  <= '0;
      clip       <= 1'b0;
      fade_level <= 9'd256;
      cnt_q      <= '0;
    end else begin
      // Clear first so a saturation in the same cycle overrides it.
      if (clip_clear) clip <= 1'b0;
      case (state_q)
        StIdle: begin
          if (audio_out_allowed) begin
            in_q[0] <= melody_in;
            in_q[1] <= kick_in;
            in_q[2] <= snare_in;
            in_q[3] <= hihat_in;
            for (int i = 0; i < 4; i++) gain_q[i] <= gains[4*i +: 4];
            state_q <= StScale;
          end
        end
        StScale: begin
          for (int i = 0; i < 4; i++) p_q[i] <= p_d[i];
          state_q <= StSumSat;
        end
        StSumSat: begin
          sat_q <= sat_d;
          if (clip_d) clip <= 1'b1;
          state_q <= StFade;
        end
        StFade: begin
          left_out  <= fade_out;
          right_out <= fade_out;
          state_q   <= StWaitWr;
        end
        StWaitWr: begin
          if (audio_out_allowed) begin
            state_q <= StIdle;
            if (cnt_q == CntW'(FADE_STEP - 1)) begin
              cnt_q <= '0;
              if (game_over) begin
                if (fade_level != 9'd0) fade_level <= fade_level - 9'd1;
              end else if (fade_level != 9'd256) begin
                fade_level <= fade_level + 9'd1;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_voice_mixer.sv
module tb_audio_voice_mixer;

  localparam int LIMIT     = 120000000;
  localparam int FADE_STEP = 2;

  logic               CLOCK_50 = 1'b0;
  logic               resetn;
  logic signed [31:0] melody_in, kick_in, snare_in, hihat_in;
  logic        [15:0] gains;
  logic               game_over, audio_out_allowed, clip_clear;
  logic signed [31:0] left_out, right_out;
  logic               write_audio_out, clip;
  logic        [8:0]  fade_level;

  audio_voice_mixer #(.LIMIT(LIMIT), .FADE_STEP(FADE_STEP)) dut (
    .CLOCK_50          (CLOCK_50),
    .resetn            (resetn),
    .melody_in         (melody_in),
    .kick_in           (kick_in),
    .snare_in          (snare_in),
    .hihat_in          (hihat_in),
    .gains             (gains),
    .game_over         (game_over),
    .audio_out_allowed (audio_out_allowed),
    .clip_clear        (clip_clear),
    .left_out          (left_out),
    .right_out         (right_out),
    .write_audio_out   (write_audio_out),
    .clip              (clip),
    .fade_level        (fade_level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [31:0] mel, kick, snare, hihat;
    logic        [15:0] g;
    logic signed [31:0] exp_out;
    logic               exp_clip;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_voices(input logic signed [31:0] m, k, s, h, input logic [15:0] g);
    melody_in = m; kick_in = k; snare_in = s; hihat_in = h; gains = g;
  endtask

  // Waits (bounded) for the next negedge with write_audio_out high.
  task automatic wait_write(output bit ok, output int at);
    ok = 0;
    at = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge CLOCK_50);
      if (write_audio_out === 1'b1) begin
        ok = 1;
        at = cyc;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: got no write, expected one within 30 cycles");
    end
  endtask

  initial begin
    bit ok;
    int at, k, nw;
    logic signed [31:0] held;

    vecs[0] = '{32'sd30000000, 32'sd0, 32'sd0, 32'sd0, 16'h000F, 32'sd28125000, 1'b0};
    vecs[1] = '{32'sd100000000, 32'sd100000000, 32'sd100000000, 32'sd100000000,
                16'hFFFF, 32'sd120000000, 1'b1};
    vecs[2] = '{-32'sd100000000, -32'sd100000000, -32'sd100000000, -32'sd100000000,
                16'hFFFF, -32'sd120000000, 1'b1};
    vecs[3] = '{32'sd1000, -32'sd1000, 32'sd0, 32'sd0, 16'h0011, -32'sd1, 1'b0};
    vecs[4] = '{32'sd100000000, 32'sd100000000, 32'sd100000000, 32'sd100000000,
                16'h0000, 32'sd0, 1'b0};
    vecs[5] = '{32'sd128000000, 32'sd0, 32'sd0, 32'sd0, 16'h000F, 32'sd120000000, 1'b0};
    vecs[6] = '{32'sd128000016, 32'sd0, 32'sd0, 32'sd0, 16'h000F, 32'sd120000000, 1'b1};
    vecs[7] = '{-32'sd128000000, 32'sd0, 32'sd0, 32'sd0, 16'h000F, -32'sd120000000, 1'b0};
    vecs[8] = '{32'sd16000000, 32'sd32000000, -32'sd48000000, 32'sd8000000,
                16'h4321, -32'sd2000000, 1'b0};
    vecs[9] = '{32'sd2147483647, -32'sd2147483648, 32'sd0, 32'sd0, 16'h00FF, -32'sd1, 1'b0};

    // Reset held with allowed toggling.
    resetn = 0; game_over = 0; clip_clear = 0; audio_out_allowed = 0;
    set_voices(32'sd30000000, 32'sd0, 32'sd0, 32'sd0, 16'h000F);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50);
      audio_out_allowed = ~audio_out_allowed;
      #1;
      check("rst_write", write_audio_out, 0);
      check("rst_left", left_out, 0);
      check("rst_fade", fade_level, 256);
      check("rst_clip", clip, 0);
    end
    @(negedge CLOCK_50);
    audio_out_allowed = 0;
    resetn = 1;
    repeat (3) begin
      @(negedge CLOCK_50);
      check("idle_no_write", write_audio_out, 0);
    end

    // Single voice: latency and cadence.
    k = cyc;
    audio_out_allowed = 1;
    wait_write(ok, at);
    if (ok) begin
      check("first_write_latency", at - k, 4);
      check("single_left", left_out, 28125000);
      check("single_right", right_out, 28125000);
    end
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLOCK_50);
      check($sformatf("cadence_%0d", i), write_audio_out, (i % 5 == 0) ? 1 : 0);
    end

    // Table-driven vectors; clip cleared before each sample is captured.
    foreach (vecs[i]) begin
      set_voices(vecs[i].mel, vecs[i].kick, vecs[i].snare, vecs[i].hihat, vecs[i].g);
      clip_clear = 1;
      @(negedge CLOCK_50);
      clip_clear = 0;
      wait_write(ok, at);
      if (ok) begin
        check($sformatf("vec%0d_left", i), left_out, vecs[i].exp_out);
        check($sformatf("vec%0d_right", i), right_out, vecs[i].exp_out);
        check($sformatf("vec%0d_clip", i), clip, vecs[i].exp_clip);
      end
    end

    // Clip: sticky, cleared by clip_clear, set wins over a simultaneous clear.
    set_voices(32'sd100000000, 32'sd100000000, 32'sd100000000, 32'sd100000000, 16'hFFFF);
    wait_write(ok, at);
    check("clip_set", clip, 1);
    set_voices(32'sd1600, 32'sd0, 32'sd0, 32'sd0, 16'h0001);
    @(negedge CLOCK_50);
    check("clip_sticky", clip, 1);
    clip_clear = 1;
    @(negedge CLOCK_50);
    clip_clear = 0;
    check("clip_cleared", clip, 0);
    wait_write(ok, at);
    check("clip_inrange_left", left_out, 100);
    check("clip_stays_clear", clip, 0);
    set_voices(32'sd100000000, 32'sd100000000, 32'sd100000000, 32'sd100000000, 16'hFFFF);
    repeat (3) @(negedge CLOCK_50);
    clip_clear = 1;  // spans exactly the SUM_SAT edge of this clipping sample
    @(negedge CLOCK_50);
    clip_clear = 0;
    check("clip_set_wins", clip, 1);
    wait_write(ok, at);
    check("clip_sat_left", left_out, 120000000);

    // Backpressure in WAIT_WR.
    set_voices(32'sd16000000, 32'sd0, 32'sd0, 32'sd0, 16'h0001);
    repeat (3) begin
      @(negedge CLOCK_50);
      check("bp_pre_no_write", write_audio_out, 0);
    end
    @(negedge CLOCK_50);
    audio_out_allowed = 0;
    check("bp_pre_no_write", write_audio_out, 0);
    @(negedge CLOCK_50);
    held = left_out;
    check("bp_held_value", held, 1000000);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge CLOCK_50);
      check("bp_no_write", write_audio_out, 0);
      check("bp_left_stable", left_out, 1000000);
    end
    audio_out_allowed = 1;
    #1;
    check("bp_release_write", write_audio_out, 1);
    check("bp_release_left", left_out, 1000000);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      check("bp_single_write", write_audio_out, 0);
    end

    // Reset in the FADE state of an in-flight sample.
    wait_write(ok, at);
    check("pre_rst_left", left_out, 1000000);
    repeat (4) @(negedge CLOCK_50);
    resetn = 0;
    #1;
    check("midrst_left", left_out, 0);
    check("midrst_right", right_out, 0);
    check("midrst_write", write_audio_out, 0);
    check("midrst_fade", fade_level, 256);
    repeat (2) begin
      @(negedge CLOCK_50);
      check("midrst_hold_write", write_audio_out, 0);
    end
    resetn = 1;
    k = cyc;
    wait_write(ok, at);
    if (ok) begin
      check("post_rst_latency", at - k, 4);
      check("post_rst_left", left_out, 1000000);
    end

    // Fresh reset so the fade sample counter starts from 0.
    audio_out_allowed = 0;
    resetn = 0;
    @(negedge CLOCK_50);
    resetn = 1;
    game_over = 1;
    set_voices(32'sd25600000, 32'sd0, 32'sd0, 32'sd0, 16'h0008);
    audio_out_allowed = 1;
    nw = 0;
    while (nw < 1030) begin
      wait_write(ok, at);
      if (!ok) break;
      nw++;
      case (nw)
        1:    check("fade_out_w1", left_out, 12800000);
        3:    check("fade_out_w3", left_out, 12750000);
        257:  check("fade_out_w257", left_out, 6400000);
        513:  check("fade_out_w513", left_out, 0);
        516:  check("fade_out_w516", left_out, 0);
        1029: check("fade_out_w1029", left_out, 12800000);
        default: ;
      endcase
      @(posedge CLOCK_50);
      #1;
      case (nw)
        1:    check("fade_after_1", fade_level, 256);
        2:    check("fade_after_2", fade_level, 255);
        256:  check("fade_after_256", fade_level, 128);
        512:  check("fade_after_512", fade_level, 0);
        516:  check("fade_floor_516", fade_level, 0);
        1027: check("fade_after_1027", fade_level, 255);
        1028: check("fade_after_1028", fade_level, 256);
        1030: check("fade_ceiling_1030", fade_level, 256);
        default: ;
      endcase
      game_over = (nw < 516);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_voice_mixer.md
# audio_voice_mixer

Output stage between the music generator and the audio codec controller. Takes the four synthesized voices (melody, kick, snare, hi-hat) as signed samples and applies a per-voice 4-bit gain to each. Sums the voices, hard-limits the result, and applies a fade ramp on game over. Writes one sample per controller handshake.

## Interface
Parameters:
- LIMIT, 120000000: symmetric clip threshold; output is held within ±LIMIT.
- FADE_STEP, 48: number of written samples per fade-level step.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  reset, asynchronous and active-low.
- melody_in, kick_in, snare_in, hihat_in  in  32 each  signed two's-complement voice samples, sampled at capture.
- gains  in  16  unsigned per-voice gain 0..15:
  - [3:0] melody, [7:4] kick, [11:8] snare, [15:12] hihat.
- game_over  in  1  level; fade out while 1, fade in while 0.
- audio_out_allowed  in  1  controller FIFO has room.
- clip_clear  in  1  one-cycle clear of the sticky clip flag.
- left_out, right_out  out  32  signed mixed sample; both carry the same value.
- write_audio_out  out  1  write strobe to the controller.
- clip  out  1  sticky flag; set when any sample exceeds ±LIMIT.
- fade_level  out  9  current gain multiplier 0..256; 256 = unity.

## Operation
- FSM states: IDLE, SCALE, SUM_SAT, FADE, WAIT_WR.
- IDLE:
  - If audio_out_allowed=1: register all four inputs and gains, go to SCALE.
  - Otherwise remain in IDLE.
- SCALE:
  - p_v = (in_v × {0,gain_v}) >>> 4 for each voice.
  - 37-bit signed product, arithmetic shift, kept at 33 bits.
  - Go to SUM_SAT.
- SUM_SAT:
  - s = sum of the four p_v, computed at 35 bits signed.
  - If s > LIMIT, sat = LIMIT; if s < −LIMIT, sat = −LIMIT; otherwise sat = s.
  - Any clip sets clip.
  - Go to FADE.
- FADE:
  - left_out = right_out = (sat × {0,fade_level}) >>> 8, truncated to 32 bits.
  - Go to WAIT_WR.
- WAIT_WR:
  - write_audio_out = audio_out_allowed, combinational in this state only.
  - When it is 1, go to IDLE at the next edge.
  - Otherwise hold; left_out and right_out stay stable.
- Fade ramp:
  - A sample counter increments on each write.
  - When the counter reaches FADE_STEP−1 it wraps to 0 and fade_level steps by one:
    - decrement (floor 0) if game_over=1;
    - increment (ceiling 256) if game_over=0.
  - At 0 the output is exactly 0.
- clip:
  - Set by SUM_SAT saturation.
  - Cleared by clip_clear.
  - If set and clear occur in the same cycle, set wins.
- Inputs are not sampled outside IDLE; changes during processing do not affect the in-flight sample.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE.
  - left_out = right_out = 0.
  - write_audio_out = 0.
  - clip = 0.
  - fade_level = 256.
  - sample counter 0.
- Capture at edge N, with IDLE and allowed=1.
  - Output registered at edge N+3.
  - write_audio_out is high during the cycle after N+3 if allowed=1.
- Minimum spacing between writes is 5 cycles: 4 processing cycles plus 1 IDLE.
- write_audio_out is never high for more than one cycle per sample.
  - It is never high outside WAIT_WR.
- Backpressure: in WAIT_WR with allowed=0, wait indefinitely; the sample is neither dropped nor duplicated.
- Reset asserted mid-sample: the in-flight sample is discarded and no write is issued.
  - After release, the FSM resumes in IDLE.
- fade_level changes only at the edge that completes a write.
  - A full fade from 256 to 0 takes 256×FADE_STEP writes.

## Test plan
- Reset: hold resetn=0 with allowed=1 toggling.
  - Required: write_audio_out=0, left_out=0, fade_level=256, clip=0 throughout.
- Single voice: melody_in=30000000, gain 15, others 0, allowed=1 constantly.
  - Required: left_out = right_out = 28125000.
  - Required: write pulses every 5 cycles, first pulse 4 cycles after capture.
- Saturation: all voices 100000000 at gain 15 (sum 375000000).
  - Required: output 120000000, clip=1.
  - Repeat with all voices at −100000000: output −120000000.
  - Pulse clip_clear with in-range input: clip=0.
  - Pulse clip_clear on a clipping sample: clip stays 1.
- Backpressure: drop allowed for 10 cycles while in WAIT_WR.
  - Required: no write, left_out stable.
  - Required: exactly one write the cycle allowed returns.
- Fade (FADE_STEP=2): melody_in=25600000, gain 8 (12800000 at unity), game_over=1.
  - Required: after 2 writes, fade_level=255 and output 12750000.
  - Required: after 512 writes, output 0.
  - Then game_over=0: fade_level reaches 256 after 512 further writes.
- Reset mid-operation: assert resetn=0 in the FADE state.
  - Required: no write, outputs 0 immediately.
  - Required: first write after release at capture+4.
